// File: rtl/memory_loader.sv
// rtl/memory_loader.sv - streams host words into the word memory while holding the CPU in reset
module memory_loader #(
  parameter logic [31:0] pWords    = 32'd44,
  parameter logic [31:0] pBaseAddr = 32'd0
) (
  input  logic        iwClk,
  input  logic        iwRst,
  input  logic        iwStart,
  input  logic        iwInValid,
  input  logic [31:0] iwInData,
  output logic        owInReady,
  output logic [31:0] owWriteAddr,
  output logic [31:0] owWriteData,
  output logic [3:0]  owWstrb,
  output logic [31:0] owCount,
  output logic        owBusy,
  output logic        owDone,
  output logic        owCpunRst
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t state, next_state;
  logic   xfer;
  logic   clear_count;

  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    xfer        = 1'b0;
    clear_count = 1'b0;
    case (state)
      IDLE: begin
        if (iwStart) begin
          next_state  = LOAD;
          clear_count = 1'b1;
        end
      end
      LOAD: begin
        xfer = iwInValid;
        if (xfer && (owCount == pWords - 32'd1)) next_state = DONE;
      end
      DONE: begin
        if (iwStart) begin
          next_state  = LOAD;
          clear_count = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Status flags decode straight from state so reset clears them without waiting for a clock.
  assign owInReady = (state == LOAD);
  assign owBusy    = (state == LOAD);
  assign owDone    = (state == DONE);
  assign owCpunRst = (state == DONE);

  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      owWriteAddr <= 32'd0;
      owWriteData <= 32'd0;
      owWstrb     <= 4'h0;
      owCount     <= 32'd0;
    end else begin
      owWstrb <= 4'h0;
      if (clear_count) owCount <= 32'd0;
      if (xfer) begin
        owWriteAddr <= pBaseAddr + (owCount << 2);
        owWriteData <= iwInData;
        owWstrb     <= 4'hF;
        owCount     <= owCount + 32'd1;
      end else if (state == DONE) begin
        // Release the write port cleanly once the final strobe has gone out.
        owWriteAddr <= 32'd0;
        owWriteData <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_memory_loader.sv
// tb/tb_memory_loader.sv - randomized check of memory_loader against a transaction-level model
module tb_memory_loader;

  localparam int ST_IDLE = 0;
  localparam int ST_LOAD = 1;
  localparam int ST_DONE = 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic        valid;
  logic [31:0] data;

  logic        ready   [2];
  logic [31:0] waddr   [2];
  logic [31:0] wdata   [2];
  logic [3:0]  wstrb   [2];
  logic [31:0] count   [2];
  logic        busy    [2];
  logic        done    [2];
  logic        cpunrst [2];

  memory_loader #(.pWords(32'd44), .pBaseAddr(32'd0)) u_dut0 (
    .iwClk(clk), .iwRst(rst), .iwStart(start), .iwInValid(valid), .iwInData(data),
    .owInReady(ready[0]), .owWriteAddr(waddr[0]), .owWriteData(wdata[0]), .owWstrb(wstrb[0]),
    .owCount(count[0]), .owBusy(busy[0]), .owDone(done[0]), .owCpunRst(cpunrst[0])
  );

  memory_loader #(.pWords(32'd4), .pBaseAddr(32'h100)) u_dut1 (
    .iwClk(clk), .iwRst(rst), .iwStart(start), .iwInValid(valid), .iwInData(data),
    .owInReady(ready[1]), .owWriteAddr(waddr[1]), .owWriteData(wdata[1]), .owWstrb(wstrb[1]),
    .owCount(count[1]), .owBusy(busy[1]), .owDone(done[1]), .owCpunRst(cpunrst[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          words    [2];
  logic [31:0] base     [2];
  int          mst      [2];
  int          mcnt     [2];
  logic [31:0] eaddr    [2];
  logic [31:0] edata    [2];
  logic [3:0]  estrb    [2];
  logic [31:0] expimg   [2][64];
  logic [31:0] cap      [2][64];
  logic [31:0] data_base;
  int          word_idx;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("ready%0d", d),   {31'b0, ready[d]},   {31'b0, mst[d] == ST_LOAD});
      check_val($sformatf("busy%0d", d),    {31'b0, busy[d]},    {31'b0, mst[d] == ST_LOAD});
      check_val($sformatf("done%0d", d),    {31'b0, done[d]},    {31'b0, mst[d] == ST_DONE});
      check_val($sformatf("cpunrst%0d", d), {31'b0, cpunrst[d]}, {31'b0, mst[d] == ST_DONE});
      check_val($sformatf("count%0d", d),   count[d],            mcnt[d]);
      check_val($sformatf("wstrb%0d", d),   {28'b0, wstrb[d]},   {28'b0, estrb[d]});
      check_val($sformatf("waddr%0d", d),   waddr[d],            eaddr[d]);
      check_val($sformatf("wdata%0d", d),   wdata[d],            edata[d]);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mst[d] = ST_IDLE; mcnt[d] = 0;
      eaddr[d] = 32'd0; edata[d] = 32'd0; estrb[d] = 4'h0;
    end
  endtask

  task automatic clear_cap();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) cap[d][i] = 32'hDEAD_DEAD;
  endtask

  // One clock: drive at negedge, advance the model over the edge, then compare 1ns after it.
  task automatic cycle(input logic s, input logic v);
    logic acc [2];
    int   pre;
    @(negedge clk);
    start = s; valid = v; data = data_base + word_idx;
    for (int d = 0; d < 2; d++) acc[d] = (mst[d] == ST_LOAD) && v;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      pre = mst[d];
      if (acc[d]) begin
        eaddr[d] = base[d] + 32'(4 * mcnt[d]);
        edata[d] = data;
        estrb[d] = 4'hF;
        expimg[d][mcnt[d]] = data;
        if (mcnt[d] == words[d] - 1) mst[d] = ST_DONE;
        mcnt[d]++;
      end else begin
        estrb[d] = 4'h0;
        if (pre == ST_DONE) begin eaddr[d] = 32'd0; edata[d] = 32'd0; end
      end
      if (s && (pre == ST_IDLE || pre == ST_DONE)) begin mst[d] = ST_LOAD; mcnt[d] = 0; end
      if (wstrb[d] == 4'hF && ((waddr[d] - base[d]) >> 2) < 64)
        cap[d][(waddr[d] - base[d]) >> 2] = wdata[d];
    end
    if (acc[0]) word_idx++;
    compare_all();
    start = 1'b0;
  endtask

  task automatic check_image();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < words[d]; i++)
        check_val($sformatf("img%0d[%0d]", d, i), cap[d][i], expimg[d][i]);
  endtask

  task automatic run_to_done(input int mode);
    int k = 0;
    bit pulsed = 0;
    while (mst[0] != ST_DONE && k < 500) begin
      logic v;
      logic s;
      case (mode)
        0: v = 1'b1;
        1: v = (k % 4 == 0) || (k % 4 == 3);
        default: v = 1'($urandom_range(0, 1));
      endcase
      s = 1'b0;
      if (mode == 1 && word_idx == 10 && !pulsed) begin s = 1'b1; pulsed = 1; end
      cycle(s, v);
      k++;
    end
    if (mst[0] != ST_DONE) check_val("load_timeout", {31'b0, done[0]}, 32'd1);
  endtask

  initial begin
    words[0] = 44; base[0] = 32'h0;
    words[1] = 4;  base[1] = 32'h100;
    rst = 1'b1; start = 1'b0; valid = 1'b0; data = 32'd0;
    data_base = 32'h1000; word_idx = 0;
    model_reset();
    clear_cap();
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Full load with valid held high.
    cycle(1'b1, 1'b0);
    run_to_done(0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    check_image();

    // Restart from DONE with a bursty host and an ignored start mid-load.
    clear_cap();
    data_base = $urandom; word_idx = 0;
    cycle(1'b1, 1'b0);
    run_to_done(1);
    check_image();

    // Back-to-back: start in the cycle right after DONE is entered, random valid.
    clear_cap();
    data_base = $urandom; word_idx = 0;
    cycle(1'b1, 1'b1);
    run_to_done(2);
    cycle(1'b0, 1'b0);
    check_image();

    // Asynchronous reset in the middle of a load.
    data_base = $urandom; word_idx = 0;
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'($urandom_range(0, 1)));
    @(negedge clk);
    valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
